// File: rtl/img_rsz_pxl_fwd.sv
// rtl/img_rsz_pxl_fwd.sv - resized pixel forwarder: FWFT buffer, X/Y tagging, image-complete handshake
module img_rsz_pxl_fwd #(
    parameter int PXL_PRIM_COLOR_W    = 8,
    parameter int PXL_PRIM_COLOR_NUM  = 3,
    parameter int RSZ_IMG_WIDTH_SIZE  = 32,
    parameter int RSZ_IMG_HEIGHT_SIZE = 32,
    parameter int FWD_BUF_DEPTH       = 4,
    parameter int RSZ_X_W             = $clog2(RSZ_IMG_WIDTH_SIZE),
    parameter int RSZ_Y_W             = $clog2(RSZ_IMG_HEIGHT_SIZE)
) (
    input  logic                        Clk_i,
    input  logic                        Reset_i,
    input  logic [PXL_PRIM_COLOR_W-1:0] RszPxlData_i [PXL_PRIM_COLOR_NUM],
    input  logic                        RszPxlVld_i,
    output logic                        RszPxlRdy_o,
    output logic [PXL_PRIM_COLOR_W-1:0] FwdPxlData_o [PXL_PRIM_COLOR_NUM],
    output logic [RSZ_X_W-1:0]          FwdPxlX_o,
    output logic [RSZ_Y_W-1:0]          FwdPxlY_o,
    output logic                        FwdPxlLast_o,
    output logic                        FwdPxlVld_o,
    input  logic                        FwdPxlRdy_i,
    output logic                        FwdRszEn_o,
    output logic                        RszImgComp_o,
    input  logic                        ImgAbort_i
);
    localparam int PTR_W = $clog2(FWD_BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(FWD_BUF_DEPTH);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1);
    localparam logic [RSZ_X_W-1:0] X_MAX   = RSZ_X_W'(RSZ_IMG_WIDTH_SIZE - 1);
    localparam logic [RSZ_Y_W-1:0] Y_MAX   = RSZ_Y_W'(RSZ_IMG_HEIGHT_SIZE - 1);
    localparam logic [RSZ_X_W-1:0] X_ONE   = RSZ_X_W'(1);
    localparam logic [RSZ_Y_W-1:0] Y_ONE   = RSZ_Y_W'(1);

    typedef enum logic [1:0] {IDLE, STREAM, COMP} state_e;

    state_e                      state_q, state_d;
    logic [PXL_PRIM_COLOR_W-1:0] buf_q [FWD_BUF_DEPTH][PXL_PRIM_COLOR_NUM];
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [RSZ_X_W-1:0]          out_x_q, out_x_d;
    logic [RSZ_Y_W-1:0]          out_y_q, out_y_d;
    logic                        push, pop;

    // Ready depends only on local state, never on FwdPxlRdy_i, so a full buffer blocks pushes even while popping.
    assign RszPxlRdy_o  = ~Reset_i & ~ImgAbort_i & (count_q < DEPTH_C) & (state_q != COMP);
    assign FwdPxlVld_o  = (count_q != '0) & (state_q == STREAM);
    assign push         = RszPxlVld_i & RszPxlRdy_o;
    assign pop          = FwdPxlVld_o & FwdPxlRdy_i & ~ImgAbort_i;
    assign FwdPxlLast_o = (out_x_q == X_MAX) & (out_y_q == Y_MAX) & FwdPxlVld_o;
    assign FwdRszEn_o   = pop;
    assign RszImgComp_o = pop & FwdPxlLast_o;
    assign FwdPxlX_o    = out_x_q;
    assign FwdPxlY_o    = out_y_q;

    always_comb begin
        for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
            FwdPxlData_o[c] = FwdPxlVld_o ? buf_q[rd_ptr_q][c] : '0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_x_d  = out_x_q;
        out_y_d  = out_y_q;
        state_d  = state_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (pop) begin
            if (out_x_q == X_MAX) begin
                out_x_d = '0;
                out_y_d = (out_y_q == Y_MAX) ? '0 : out_y_q + Y_ONE;
            end else begin
                out_x_d = out_x_q + X_ONE;
            end
        end

        unique case (state_q)
            IDLE:    if (push) state_d = STREAM;
            STREAM:  if (RszImgComp_o) state_d = COMP;
            COMP:    state_d = (count_q == '0) ? IDLE : STREAM;
            default: state_d = IDLE;
        endcase

        if (ImgAbort_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            out_x_d  = '0;
            out_y_d  = '0;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_x_q  <= '0;
            out_y_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_x_q  <= out_x_d;
            out_y_q  <= out_y_d;
        end
    end

    // Pixel storage needs no reset: it is only observable through count_q.
    always_ff @(posedge Clk_i) begin
        if (push) buf_q[wr_ptr_q] <= RszPxlData_i;
    end
endmodule

// File: tb/tb_img_rsz_pxl_fwd.sv
// tb/tb_img_rsz_pxl_fwd.sv - directed self-checking bench for img_rsz_pxl_fwd (4x4 image, depth 4)
module tb_img_rsz_pxl_fwd;
    logic       clk, rst;
    logic [7:0] rsz_data [3];
    logic       rsz_vld, rsz_rdy;
    logic [7:0] fwd_data [3];
    logic [1:0] fwd_x, fwd_y;
    logic       fwd_last, fwd_vld, fwd_rdy, fwd_en, img_comp, img_abort;

    int  n_tests, n_fail;
    int  in_idx, out_idx, base, in_limit;
    bit  comp_prev;
    int  n_en, n_comp, e0, c0;

    img_rsz_pxl_fwd #(
        .PXL_PRIM_COLOR_W(8), .PXL_PRIM_COLOR_NUM(3),
        .RSZ_IMG_WIDTH_SIZE(4), .RSZ_IMG_HEIGHT_SIZE(4), .FWD_BUF_DEPTH(4)
    ) dut (
        .Clk_i(clk), .Reset_i(rst),
        .RszPxlData_i(rsz_data), .RszPxlVld_i(rsz_vld), .RszPxlRdy_o(rsz_rdy),
        .FwdPxlData_o(fwd_data), .FwdPxlX_o(fwd_x), .FwdPxlY_o(fwd_y),
        .FwdPxlLast_o(fwd_last), .FwdPxlVld_o(fwd_vld), .FwdPxlRdy_i(fwd_rdy),
        .FwdRszEn_o(fwd_en), .RszImgComp_o(img_comp), .ImgAbort_i(img_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int i, input int c);
        return 8'(i + c * 85);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic r);
        int   cnt, pos;
        logic exp_vld, exp_rdy, exp_last, exp_pop;
        rsz_vld = v && (in_idx < in_limit);
        for (int c = 0; c < 3; c++) rsz_data[c] = pix(in_idx, c);
        fwd_rdy   = r;
        img_abort = 1'b0;
        @(negedge clk);
        cnt      = in_idx - out_idx;
        pos      = out_idx - base;
        exp_vld  = (cnt != 0) && !comp_prev;
        exp_rdy  = (cnt < 4) && !comp_prev;
        exp_last = exp_vld && (pos % 16 == 15);
        exp_pop  = exp_vld && r;
        chk("vld", 32'(fwd_vld), 32'(exp_vld));
        chk("rdy", 32'(rsz_rdy), 32'(exp_rdy));
        chk("en", 32'(fwd_en), 32'(exp_pop));
        chk("comp", 32'(img_comp), 32'(exp_pop && exp_last));
        if (exp_vld) begin
            chk("data", {8'h0, fwd_data[2], fwd_data[1], fwd_data[0]},
                {8'h0, pix(out_idx, 2), pix(out_idx, 1), pix(out_idx, 0)});
            chk("x", 32'(fwd_x), 32'(pos % 4));
            chk("y", 32'(fwd_y), 32'((pos / 4) % 4));
            chk("last", 32'(fwd_last), 32'(exp_last));
        end
        if (fwd_en) n_en++;
        if (img_comp) n_comp++;
        @(posedge clk);
        #1;
        if (rsz_vld && exp_rdy) in_idx++;
        if (exp_pop) out_idx++;
        comp_prev = exp_pop && exp_last;
    endtask

    task automatic drain(input int target, input bit rnd);
        int k;
        k = 0;
        while (out_idx < target && k < 2000) begin
            if (rnd) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else     step(1'b1, 1'b1);
            k++;
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    task automatic model_flush();
        out_idx   = in_idx;
        base      = in_idx;
        comp_prev = 1'b0;
        in_limit  = in_idx + 16;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vld"}, 32'(fwd_vld), 0);
        chk({tag, "_rdy"}, 32'(rsz_rdy), 0);
        chk({tag, "_x"}, 32'(fwd_x), 0);
        chk({tag, "_y"}, 32'(fwd_y), 0);
        chk({tag, "_last"}, 32'(fwd_last), 0);
        chk({tag, "_en"}, 32'(fwd_en), 0);
        chk({tag, "_comp"}, 32'(img_comp), 0);
        chk({tag, "_data"}, {8'h0, fwd_data[2], fwd_data[1], fwd_data[0]}, 0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; n_en = 0; n_comp = 0;
        in_idx = 0; out_idx = 0; base = 0; in_limit = 0; comp_prev = 1'b0;
        rst = 1'b1; rsz_vld = 1'b1; fwd_rdy = 1'b1; img_abort = 1'b0;
        for (int c = 0; c < 3; c++) rsz_data[c] = 8'hA5;
        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: back-to-back image, one-cycle latency
        in_limit = 16; e0 = n_en; c0 = n_comp;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
        chk("t1_en_pulses", 32'(n_en - e0), 16);
        chk("t1_comp_pulses", 32'(n_comp - c0), 1);

        // 2: stalled output, 6 offered, buffer fills at 4
        in_limit = in_idx + 16;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        drain(in_limit, 1'b0);

        // 3: three images with random handshakes
        in_limit = in_idx + 48; e0 = n_en; c0 = n_comp;
        drain(in_limit, 1'b1);
        chk("t3_en_pulses", 32'(n_en - e0), 48);
        chk("t3_comp_pulses", 32'(n_comp - c0), 3);

        // 4: next image already buffered when the last pixel leaves
        in_limit = in_idx + 32;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        drain(in_limit, 1'b0);

        // 5: abort after 5 pops with 3 pixels buffered
        in_limit = in_idx + 16;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        rsz_vld = 1'b1; fwd_rdy = 1'b1; img_abort = 1'b1;
        @(negedge clk);
        chk("abort_rdy", 32'(rsz_rdy), 0);
        chk("abort_en", 32'(fwd_en), 0);
        chk("abort_comp", 32'(img_comp), 0);
        @(posedge clk);
        #1;
        img_abort = 1'b0;
        model_flush();
        chk("post_abort_vld", 32'(fwd_vld), 0);
        chk("post_abort_x", 32'(fwd_x), 0);
        chk("post_abort_y", 32'(fwd_y), 0);
        drain(in_limit, 1'b0);

        // 6: asynchronous reset in the middle of an image
        in_limit = in_idx + 16;
        begin
            int k;
            k = 0;
            while (out_idx - base < 9 && k < 100) begin
                step(1'b1, 1'b1);
                k++;
            end
        end
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_flush();
        e0 = n_en; c0 = n_comp;
        drain(in_limit, 1'b0);
        chk("t6_en_pulses", 32'(n_en - e0), 16);
        chk("t6_comp_pulses", 32'(n_comp - c0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/img_rsz_pxl_fwd.md
Name: img_rsz_pxl_fwd

Overview:
Resized Pixel Forwarder: the transmit end of the resizer. It takes resized pixels from the Resizer Compute Engine in raster order and buffers them. It drives them out on a valid/ready pixel stream, tagging each pixel with its X/Y coordinate in the resized image. Per accepted pixel it pulses FwdRszEn, and on the last pixel of the image it pulses RszImgComp. Both are consumed by the image capturer to release back-pressure for the next image.

Parameters:
PXL_PRIM_COLOR_W, 8, bits per primary colour.
PXL_PRIM_COLOR_NUM, 3, primary colours per pixel.
RSZ_IMG_WIDTH_SIZE, 32, resized image width in pixels; power of 2, >=2.
RSZ_IMG_HEIGHT_SIZE, 32, resized image height in pixels; power of 2, >=2.
FWD_BUF_DEPTH, 4, output buffer depth in pixels; power of 2, >=2.
RSZ_X_W, $clog2(RSZ_IMG_WIDTH_SIZE), derived X coordinate width.
RSZ_Y_W, $clog2(RSZ_IMG_HEIGHT_SIZE), derived Y coordinate width.

Ports:
Clk  in  1  clock, rising edge.
Reset  in  1  asynchronous, active-high reset.
RszPxlData  in  PXL_PRIM_COLOR_W x PXL_PRIM_COLOR_NUM (unpacked)  resized pixel from compute engine.
RszPxlVld  in  1  compute-engine pixel valid.
RszPxlRdy  out  1  forwarder can accept a pixel.
FwdPxlData  out  PXL_PRIM_COLOR_W x PXL_PRIM_COLOR_NUM (unpacked)  forwarded pixel.
FwdPxlX  out  RSZ_X_W  column of FwdPxlData.
FwdPxlY  out  RSZ_Y_W  row of FwdPxlData.
FwdPxlLast  out  1  FwdPxlData is the last pixel of the image.
FwdPxlVld  out  1  output valid.
FwdPxlRdy  in  1  downstream ready.
FwdRszEn  out  1  one-cycle pulse per accepted output pixel.
RszImgComp  out  1  one-cycle pulse when the last pixel is accepted.
ImgAbort  in  1  synchronous flush of buffer, counters and FSM.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: FwdPxlVld=0, FwdPxlX=0, FwdPxlY=0, FwdPxlLast=0, FwdRszEn=0, RszImgComp=0, FwdPxlData=0, RszPxlRdy=0 during reset.
  - Buffer is empty and FSM is IDLE.
- Input handshake:
  - Push occurs when RszPxlVld & RszPxlRdy.
  - RszPxlRdy = (count < FWD_BUF_DEPTH) & (state != COMP).
  - RszPxlRdy has no combinational path from FwdPxlRdy. When the buffer is full, no push happens even if a pop occurs in the same cycle.
- Output handshake:
  - Pop occurs when FwdPxlVld & FwdPxlRdy.
  - FwdPxlVld = (count != 0) & (state == STREAM).
  - FwdPxlData shows the buffer head (first-word fall-through).
  - Latency: a pixel pushed in cycle N is visible with FwdPxlVld=1 in cycle N+1 at the earliest.
  - While FwdPxlVld=1 and FwdPxlRdy=0, FwdPxlData, X, Y and Last hold stable.
- Simultaneous push and pop with count between 1 and DEPTH-1: count is unchanged and ordering is preserved.
- Coordinate counters OutX/OutY drive FwdPxlX/FwdPxlY directly and advance only on pop:
  - OutX increments.
  - At OutX==RSZ_IMG_WIDTH_SIZE-1, OutX wraps to 0 and OutY increments.
  - FwdPxlLast = (OutX==W-1) & (OutY==H-1) & FwdPxlVld.
- FwdRszEn is combinational and equals the pop condition.
- FSM:
  - IDLE -> STREAM on the first push. Pixels may be pushed in IDLE.
  - STREAM -> COMP on a pop with FwdPxlLast=1. In that same cycle RszImgComp=1, and OutX and OutY wrap to 0 on the next edge.
  - COMP lasts exactly 1 cycle. Input is blocked and output is invalid. Then go to IDLE if count==0, else STREAM.
  - Pixels of the next image already buffered stay intact.
- ImgAbort=1:
  - Next edge: buffer is emptied, OutX=OutY=0, FSM goes to IDLE.
  - In the abort cycle itself: no push accepted (RszPxlRdy=0), FwdRszEn=0, RszImgComp=0.
  - ImgAbort takes priority over every other event.
- Async Reset mid-image: all state is cleared immediately. There is no partial-image resumption.
- Widths: counter compares use the full RSZ_X_W/RSZ_Y_W width. There is no overflow, because W and H are powers of 2 and wrap is explicit.

Test Plan:
1. W=H=4, DEPTH=4, FwdPxlRdy=1, 16 back-to-back pixels with data=index -> output X/Y run (0,0)..(3,3) in raster order. FwdRszEn is high for 16 cycles, FwdPxlLast and RszImgComp are high only on the pixel with data=15, and first-in to first-out latency is 1 cycle.
2. FwdPxlRdy=0 while 6 pixels are offered -> 4 are accepted, RszPxlRdy=0 afterwards, and the outputs stay stable at (0,0) data=0. Raising FwdPxlRdy then drains in order.
3. Random FwdPxlRdy and RszPxlVld at 50% over 3 images (48 pixels) -> no loss, duplication or reordering. Exactly 3 RszImgComp pulses and 48 FwdRszEn pulses.
4. Pixel 16 (the next image) is pushed before the last pixel pops -> one COMP cycle with FwdPxlVld=0 and RszPxlRdy=0. The next cycle outputs pixel 16 at (0,0).
5. ImgAbort after 5 pops with 3 pixels buffered -> next cycle FwdPxlVld=0, X=Y=0, state IDLE. A subsequent image starts at (0,0).
6. Reset asserted asynchronously mid-cycle at pixel 9 -> all outputs are 0 immediately. After release, a fresh 16-pixel image completes normally.
